memcore_uram_pipelined: RTL and testbench

Simple-dual-port (1W/1R) UltraRAM memory core with byte-granular write enables, a configurable read pipeline depth for cascaded URAM timing closure, same-cycle write-to-read bypass, and a read-valid strobe. Successor to the single-latency URAM core; it sits under TAPA stream/buffer channels wherever a deep buffer must close timing at high clock rates.

---
 rtl/memcore_uram_pipelined.sv | 100 ++++++++++
 tb/tb_memcore_uram_pipelined.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/memcore_uram_pipelined.sv
// Simple-dual-port UltraRAM core: byte-enabled write port, pipelined read port
// with configurable latency, optional same-cycle write-to-read bypass.

module memcore_uram_lane #(
    parameter int BYTE_WIDTH = 8
) (
    input  logic [BYTE_WIDTH-1:0] old_i,
    input  logic [BYTE_WIDTH-1:0] new_i,
    input  logic                  sel_i,
    output logic [BYTE_WIDTH-1:0] lane_o
);
    assign lane_o = sel_i ? new_i : old_i;
endmodule

module memcore_uram_pipelined #(
    parameter int DATA_WIDTH    = 32,
    parameter int BYTE_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 6,
    parameter int ADDRESS_RANGE = 64,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_BYPASS  = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [ADDRESS_WIDTH-1:0]        address0,
    input  logic                            ce0,
    input  logic                            we0,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be0,
    input  logic [DATA_WIDTH-1:0]           d0,
    input  logic [ADDRESS_WIDTH-1:0]        address1,
    input  logic                            ce1,
    output logic [DATA_WIDTH-1:0]           q1,
    output logic                            q1_valid
);
    localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam int STAGES    = READ_LATENCY - 1;
    localparam logic [ADDRESS_WIDTH:0] RANGE_W = (ADDRESS_WIDTH+1)'(ADDRESS_RANGE);

    (* ram_style = "hls_ultra", cascade_height = 16 *)
    logic [DATA_WIDTH-1:0] ram [0:ADDRESS_RANGE-1];

    logic                  wr_in_range, rd_in_range, wr_en, issue, same_addr;
    logic [DATA_WIDTH-1:0] rd_old, rd_word;
    logic [NUM_BYTES-1:0]  byp_sel;

    assign wr_in_range = {1'b0, address0} < RANGE_W;
    assign rd_in_range = {1'b0, address1} < RANGE_W;
    assign wr_en       = ce0 & we0 & ~reset & wr_in_range;
    assign issue       = ce1 & ~reset;
    assign same_addr   = (address0 == address1);
    assign rd_old      = rd_in_range ? ram[address1] : '0;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (be0[i]) ram[address0][i*BYTE_WIDTH +: BYTE_WIDTH] <= d0[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Collision merge: an in-range write to the read address overrides enabled lanes.
    for (genvar g = 0; g < NUM_BYTES; g++) begin : g_lane
        assign byp_sel[g] = (WRITE_BYPASS != 0) & wr_en & same_addr & be0[g];
        memcore_uram_lane #(.BYTE_WIDTH(BYTE_WIDTH)) u_lane (
            .old_i  (rd_old[g*BYTE_WIDTH +: BYTE_WIDTH]),
            .new_i  (d0[g*BYTE_WIDTH +: BYTE_WIDTH]),
            .sel_i  (byp_sel[g]),
            .lane_o (rd_word[g*BYTE_WIDTH +: BYTE_WIDTH])
        );
    end

    logic [STAGES:0]                 vld_pipe, vld_d;
    logic [STAGES:0][DATA_WIDTH-1:0] stage_q, stage_d;

    always_comb begin
        vld_d      = '0;
        stage_d    = '0;
        vld_d[0]   = issue;
        stage_d[0] = rd_word;
        for (int k = 1; k <= STAGES; k++) begin
            vld_d[k]   = vld_pipe[k-1];
            stage_d[k] = stage_q[k-1];
        end
        // Last stage drives q1 and holds between returned reads.
        if (!vld_d[STAGES]) stage_d[STAGES] = stage_q[STAGES];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
            stage_q  <= '0;
        end else begin
            vld_pipe <= vld_d;
            stage_q  <= stage_d;
        end
    end

    assign q1       = stage_q[STAGES];
    assign q1_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_memcore_uram_pipelined.sv
// Scoreboard bench: six cores with different latency/bypass/range share one
// stimulus stream; a word-level model predicts each read and its return cycle.

module tb_memcore_uram_pipelined;
    localparam int NDUT = 6;

    function automatic int lat_of(input int d);
        case (d)
            2: return 1;
            3: return 4;
            4: return 8;
            default: return 2;
        endcase
    endfunction
    function automatic int byp_of(input int d);
        return (d == 1) ? 0 : 1;
    endfunction
    function automatic int rng_of(input int d);
        return (d == 5) ? 48 : 64;
    endfunction

    logic        clk, reset, ce0, we0, ce1;
    logic [5:0]  address0, address1;
    logic [3:0]  be0;
    logic [31:0] d0;
    logic [31:0] q1_w [NDUT];
    logic        v_w  [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        memcore_uram_pipelined #(
            .DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDRESS_WIDTH(6),
            .ADDRESS_RANGE(rng_of(g)), .READ_LATENCY(lat_of(g)), .WRITE_BYPASS(byp_of(g))
        ) u_dut (
            .clk(clk), .reset(reset), .address0(address0), .ce0(ce0), .we0(we0),
            .be0(be0), .d0(d0), .address1(address1), .ce1(ce1),
            .q1(q1_w[g]), .q1_valid(v_w[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    exp_t        sbq [NDUT][$];
    logic [31:0] last_q [NDUT];
    logic [31:0] mem64 [64];
    logic [31:0] mem48 [48];
    int          cyc, errs, nchk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input int d, input logic wr, input logic [5:0] wa,
                                                input logic [3:0] be, input logic [31:0] wd,
                                                input logic [5:0] ra);
        logic [31:0] w;
        if (int'(ra) >= rng_of(d)) return 32'h0;
        w = (rng_of(d) == 48) ? mem48[ra] : mem64[ra];
        if (byp_of(d) != 0 && wr && wa == ra)
            for (int i = 0; i < 4; i++) if (be[i]) w[i*8 +: 8] = wd[i*8 +: 8];
        return w;
    endfunction

    task automatic step(input logic rst, input logic c0, input logic w0, input logic [5:0] wa,
                        input logic [3:0] be, input logic [31:0] wd, input logic rd,
                        input logic [5:0] ra);
        exp_t e;
        logic wr, exp_v;
        wr = c0 & w0;
        reset = rst; ce0 = c0; we0 = w0; address0 = wa; be0 = be; d0 = wd;
        ce1 = rd; address1 = ra;
        for (int d = 0; d < NDUT; d++) begin
            if (rst) begin
                sbq[d].delete();
                last_q[d] = '0;
            end else if (rd) begin
                e.due  = cyc + lat_of(d);
                e.data = model_read(d, wr, wa, be, wd, ra);
                sbq[d].push_back(e);
            end
        end
        if (!rst && wr) begin
            for (int i = 0; i < 4; i++) if (be[i]) begin
                mem64[wa][i*8 +: 8] = wd[i*8 +: 8];
                if (wa < 48) mem48[wa][i*8 +: 8] = wd[i*8 +: 8];
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            exp_v = (sbq[d].size() > 0) && (sbq[d][0].due == cyc);
            if (exp_v) begin
                last_q[d] = sbq[d][0].data;
                void'(sbq[d].pop_front());
            end
            check($sformatf("valid[%0d]", d), {31'b0, v_w[d]}, {31'b0, exp_v});
            check($sformatf("q1[%0d]", d), q1_w[d], last_q[d]);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 6'd0, 4'h0, 32'h0, 0, 6'd0);
    endtask

    initial begin
        logic [5:0] wa, ra;
        cyc = 0; errs = 0; nchk = 0;
        for (int d = 0; d < NDUT; d++) last_q[d] = '0;

        // Reset; write and read presented under reset must be ignored.
        step(1, 0, 0, 6'd0, 4'h0, 32'h0, 0, 6'd0);
        step(1, 1, 1, 6'd9, 4'hF, 32'hBAD0BAD0, 1, 6'd9);
        step(1, 0, 0, 6'd0, 4'h0, 32'h0, 1, 6'd1);

        for (int n = 0; n < 64; n++) step(0, 1, 1, 6'(n), 4'hF, 32'(n * 3), 0, 6'd0);
        step(0, 1, 0, 6'd4, 4'hF, 32'hFFFFFFFF, 0, 6'd0);   // ce0 without we0
        step(0, 0, 0, 6'd0, 4'h0, 32'h0, 1, 6'd9);
        step(0, 0, 0, 6'd0, 4'h0, 32'h0, 1, 6'd4);
        idle(9);

        // Streaming 0..15 back to back
        for (int n = 0; n < 16; n++) step(0, 0, 0, 6'd0, 4'h0, 32'h0, 1, 6'(n));
        idle(9);

        // Basic latency
        step(0, 1, 1, 6'd5, 4'hF, 32'hDEADBEEF, 0, 6'd0);
        step(0, 0, 0, 6'd0, 4'h0, 32'h0, 1, 6'd5);
        idle(9);

        // Byte enables
        step(0, 1, 1, 6'd3, 4'hF, 32'h11223344, 0, 6'd0);
        step(0, 1, 1, 6'd3, 4'b0101, 32'hAABBCCDD, 0, 6'd0);
        step(0, 1, 1, 6'd8, 4'h0, 32'h77777777, 1, 6'd3);   // be0=0 no-op
        step(0, 0, 0, 6'd0, 4'h0, 32'h0, 1, 6'd8);
        idle(9);

        // Collision
        step(0, 1, 1, 6'd7, 4'hF, 32'h0, 0, 6'd0);
        step(0, 1, 1, 6'd7, 4'b1100, 32'hFFFFFFFF, 1, 6'd7);
        step(0, 0, 0, 6'd0, 4'h0, 32'h0, 1, 6'd7);
        idle(9);

        // Range (48-word core drops addr 50, no aliasing onto addr 2)
        step(0, 1, 1, 6'd50, 4'hF, 32'h12345678, 0, 6'd0);
        step(0, 0, 0, 6'd0, 4'h0, 32'h0, 1, 6'd50);
        step(0, 0, 0, 6'd0, 4'h0, 32'h0, 1, 6'd2);
        step(0, 1, 1, 6'd60, 4'hF, 32'hCAFEF00D, 1, 6'd60);
        idle(9);

        // Reset mid-flight
        step(0, 0, 0, 6'd0, 4'h0, 32'h0, 1, 6'd0);
        step(0, 0, 0, 6'd0, 4'h0, 32'h0, 1, 6'd1);
        step(1, 0, 0, 6'd0, 4'h0, 32'h0, 1, 6'd2);
        idle(9);
        step(0, 0, 0, 6'd0, 4'h0, 32'h0, 1, 6'd5);
        step(0, 0, 0, 6'd0, 4'h0, 32'h0, 1, 6'd3);
        idle(9);

        // Random mix with frequent collisions and occasional resets
        for (int i = 0; i < 400; i++) begin
            wa = 6'($urandom_range(0, 63));
            ra = ($urandom_range(0, 2) == 0) ? wa : 6'($urandom_range(0, 63));
            step(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 wa, 4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)), ra);
        end
        idle(12);

        for (int d = 0; d < NDUT; d++) check($sformatf("drain[%0d]", d), 32'(sbq[d].size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end
endmodule
